alu_mc: RTL and testbench

Multi-cycle, parametrised successor to the single-cycle datapath ALU, for the multi-cycle and pipelined MIPS cores. It keeps the existing 4-bit operation encoding for the logic, add/sub and compare operations and adds signed/unsigned multiply and divide. Multiply and divide run on an iterative unit that writes the architectural HI/LO registers. A valid/ready input handshake and a registered, one-cycle `out_valid` result pulse let the control FSM stall on long operations.

---
 rtl/alu_pkg.sv | 28 ++
 rtl/alu_muldiv_iter.sv | 134 +++++++++++++
 rtl/alu_mc.sv | 146 ++++++++++++++
 tb/tb_alu_mc.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_mc shared definitions: operation codes, top FSM states and
// the helper that splits iterative from single-cycle operations.
package alu_pkg;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_SLTU  = 4'b1000;
  localparam logic [3:0] OP_MULT  = 4'b1001;
  localparam logic [3:0] OP_MULTU = 4'b1010;
  localparam logic [3:0] OP_DIV   = 4'b1011;
  localparam logic [3:0] OP_NOR   = 4'b1100;
  localparam logic [3:0] OP_DIVU  = 4'b1101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2
  } state_t;

  function automatic logic is_iterative(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) ||
           (op == OP_DIV)  || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative multiply/divide engine working on operand magnitudes.
// Ports: clk, reset; start_i/op_i/a_i/b_i load an operation;
// fix_o flags the sign-fix cycle; hi_o/lo_o hold the final result.
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic [3:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             fix_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CW = $clog2(WIDTH + 1);

  logic               busy_q;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   m_q;
  logic               div_q;
  logic               neg_q;
  logic               rneg_q;
  logic               dz_q;
  logic [WIDTH-1:0]   araw_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;

  logic               sgn;
  logic               is_div;
  logic               sa;
  logic               sb;
  logic [WIDTH-1:0]   amag;
  logic [WIDTH-1:0]   bmag;

  logic [WIDTH-1:0]   addend;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_nxt;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     diff;
  logic [2*WIDTH-1:0] div_nxt;

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;

  always_comb begin
    sgn    = (op_i == OP_MULT) || (op_i == OP_DIV);
    is_div = (op_i == OP_DIV) || (op_i == OP_DIVU);
    sa     = sgn & a_i[WIDTH-1];
    sb     = sgn & b_i[WIDTH-1];
    // negating the most-negative value yields 2^(WIDTH-1),
    // which is the correct unsigned magnitude
    amag   = sa ? -a_i : a_i;
    bmag   = sb ? -b_i : b_i;
  end

  // shift-add: low half holds the multiplier, consumed LSB first
  always_comb begin
    addend  = acc_q[0] ? m_q : '0;
    mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    mul_nxt = {mul_sum, acc_q[WIDTH-1:1]};
  end

  // restoring divide: {remainder, dividend/quotient}
  always_comb begin
    rem_sh = acc_q[2*WIDTH-1:WIDTH-1];
    diff   = rem_sh - {1'b0, m_q};
    if (diff[WIDTH])
      div_nxt = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    else
      div_nxt = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
  end

  always_comb begin
    prod   = neg_q ? -acc_q : acc_q;
    quo    = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem    = rneg_q ? -acc_q[2*WIDTH-1:WIDTH]
                    : acc_q[2*WIDTH-1:WIDTH];
    fix_hi = prod[2*WIDTH-1:WIDTH];
    fix_lo = prod[WIDTH-1:0];
    if (div_q) begin
      fix_hi = dz_q ? araw_q : rem;
      fix_lo = dz_q ? '1 : quo;
    end
  end

  assign fix_o = busy_q && (cnt_q == CW'(WIDTH));
  assign hi_o  = hi_q;
  assign lo_o  = lo_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      acc_q  <= '0;
      m_q    <= '0;
      div_q  <= 1'b0;
      neg_q  <= 1'b0;
      rneg_q <= 1'b0;
      dz_q   <= 1'b0;
      araw_q <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else if (start_i) begin
      busy_q <= 1'b1;
      cnt_q  <= '0;
      acc_q  <= {{WIDTH{1'b0}}, amag};
      m_q    <= bmag;
      div_q  <= is_div;
      neg_q  <= sa ^ sb;
      rneg_q <= sa;
      dz_q   <= (b_i == '0);
      araw_q <= a_i;
    end else if (busy_q) begin
      if (cnt_q == CW'(WIDTH)) begin
        busy_q <= 1'b0;
        hi_q   <= fix_hi;
        lo_q   <= fix_lo;
      end else begin
        acc_q <= div_q ? div_nxt : mul_nxt;
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arith/compare plus iterative
// mul/div into HI/LO. Ports: clk, reset, in_valid/in_ready handshake,
// A, B, ALUOperation; out_valid pulse, ALUResult, Zero, Overflow, HI, LO.
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALUOperation,
  output logic             out_valid,
  output logic [WIDTH-1:0] ALUResult,
  output logic             Zero,
  output logic             Overflow,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             ovf_q, ovf_d;
  logic             ov_q, ov_d;

  logic             accept;
  logic             start;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] dif;
  logic [WIDTH-1:0] s_res;
  logic             s_ovf;
  logic             it_fix;
  logic [WIDTH-1:0] it_hi;
  logic [WIDTH-1:0] it_lo;

  assign in_ready = (state_q == IDLE);
  assign accept   = in_valid && in_ready;
  assign sum      = A + B;
  assign dif      = A - B;

  always_comb begin
    s_res = '0;
    s_ovf = 1'b0;
    case (ALUOperation)
      OP_AND:  s_res = A & B;
      OP_OR:   s_res = A | B;
      OP_NOR:  s_res = ~(A | B);
      OP_ADD: begin
        s_res = sum;
        s_ovf = (A[WIDTH-1] == B[WIDTH-1]) &&
                (sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        s_res = dif;
        s_ovf = (A[WIDTH-1] != B[WIDTH-1]) &&
                (dif[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SLT:
        s_res = {{(WIDTH-1){1'b0}}, $signed(A) < $signed(B)};
      OP_SLTU:
        s_res = {{(WIDTH-1){1'b0}}, A < B};
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    ovf_d   = ovf_q;
    ov_d    = 1'b0;
    start   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_iterative(ALUOperation)) begin
            start   = 1'b1;
            state_d = ITER;
          end else begin
            res_d = s_res;
            ovf_d = s_ovf;
            ov_d  = 1'b1;
          end
        end
      end
      ITER: begin
        if (it_fix) state_d = FIX;
      end
      FIX: begin
        hi_d    = it_hi;
        lo_d    = it_lo;
        res_d   = it_lo;
        ovf_d   = 1'b0;
        ov_d    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      res_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      ovf_q   <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      ovf_q   <= ovf_d;
      ov_q    <= ov_d;
    end
  end

  alu_muldiv_iter #(
    .WIDTH(WIDTH)
  ) u_iter (
    .clk    (clk),
    .reset  (reset),
    .start_i(start),
    .op_i   (ALUOperation),
    .a_i    (A),
    .b_i    (B),
    .fix_o  (it_fix),
    .hi_o   (it_hi),
    .lo_o   (it_lo)
  );

  assign out_valid = ov_q;
  assign ALUResult = res_q;
  assign Zero      = (res_q == '0);
  assign Overflow  = ovf_q;
  assign HI        = hi_q;
  assign LO        = lo_q;

endmodule

// File: tb/tb_alu_mc.sv
// Directed scoreboard bench for alu_mc (WIDTH = 32).
// Expected results are queued at issue and popped on out_valid.
module tb_alu_mc;

  localparam int W = 32;

  localparam logic [3:0] C_AND   = 4'b0000;
  localparam logic [3:0] C_OR    = 4'b0001;
  localparam logic [3:0] C_ADD   = 4'b0010;
  localparam logic [3:0] C_SUB   = 4'b0110;
  localparam logic [3:0] C_SLT   = 4'b0111;
  localparam logic [3:0] C_SLTU  = 4'b1000;
  localparam logic [3:0] C_MULT  = 4'b1001;
  localparam logic [3:0] C_MULTU = 4'b1010;
  localparam logic [3:0] C_DIV   = 4'b1011;
  localparam logic [3:0] C_NOR   = 4'b1100;
  localparam logic [3:0] C_DIVU  = 4'b1101;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [3:0]   op;
  logic         out_valid;
  logic [W-1:0] res;
  logic         zero;
  logic         ovf;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  alu_mc #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .A           (A),
    .B           (B),
    .ALUOperation(op),
    .out_valid   (out_valid),
    .ALUResult   (res),
    .Zero        (zero),
    .Overflow    (ovf),
    .HI          (hi),
    .LO          (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    logic         ovf;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    string        tag;
  } exp_t;

  exp_t         sbq[$];
  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] mhi = '0;
  logic [W-1:0] mlo = '0;
  int           edges;
  int           lows;
  int           stray;

  task automatic chk(input string tag, input logic [W-1:0] o,
                     input logic [W-1:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed 0x%h expected 0x%h", tag, o, e);
    end
  endtask

  task automatic push(input string tag, input logic [W-1:0] r,
                      input logic v);
    exp_t e;
    e.res = r;
    e.ovf = v;
    e.hi  = mhi;
    e.lo  = mlo;
    e.tag = tag;
    sbq.push_back(e);
  endtask

  task automatic drive(input logic [3:0] o, input logic [W-1:0] a,
                       input logic [W-1:0] b);
    op       = o;
    A        = a;
    B        = b;
    in_valid = 1'b1;
  endtask

  task automatic pop_check();
    exp_t e;
    if (sbq.size() == 0) begin
      chk("unexpected_out_valid", W'(out_valid), '0);
    end else begin
      e = sbq.pop_front();
      chk({e.tag, "_res"},  res,          e.res);
      chk({e.tag, "_zero"}, W'(zero),     W'(e.res == '0));
      chk({e.tag, "_ovf"},  W'(ovf),      W'(e.ovf));
      chk({e.tag, "_hi"},   hi,           e.hi);
      chk({e.tag, "_lo"},   lo,           e.lo);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (out_valid) pop_check();
  endtask

  // caller has driven an iterative op; this waits for its completion
  task automatic run_iter(input string tag, input bit hold,
                          input logic [3:0] nop,
                          input logic [W-1:0] na,
                          input logic [W-1:0] nb,
                          output int e_n, output int l_n);
    logic [W-1:0] hi0;
    logic [W-1:0] lo0;
    int leak;
    e_n  = -1;
    l_n  = 0;
    leak = 0;
    @(posedge clk);
    #1;
    if (hold) drive(nop, na, nb);
    else in_valid = 1'b0;
    hi0 = hi;
    lo0 = lo;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        e_n = n;
        break;
      end
      if (!in_ready) l_n++;
      if (hi !== hi0 || lo !== lo0) leak++;
    end
    chk({tag, "_hilo_hidden"}, W'(leak), '0);
    if (e_n < 0) begin
      chk({tag, "_timeout"}, W'(out_valid), W'(1));
    end else begin
      pop_check();
      chk({tag, "_ready_at_done"}, W'(in_ready), W'(1));
    end
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    A        = '0;
    B        = '0;
    op       = C_AND;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready",  W'(in_ready),  W'(1));
    chk("rst_out_valid", W'(out_valid), '0);
    chk("rst_result",    res,           '0);
    chk("rst_zero",      W'(zero),      W'(1));
    chk("rst_ovf",       W'(ovf),       '0);
    chk("rst_hi",        hi,            '0);
    chk("rst_lo",        lo,            '0);
    reset = 1'b0;

    drive(C_ADD, 32'h7FFF_FFFF, 32'h1);
    push("add_ovf", 32'h8000_0000, 1'b1);
    tick();
    chk("add_ovf_valid", W'(out_valid), W'(1));

    drive(C_SUB, 32'd5, 32'd5);
    push("sub_zero", 32'h0, 1'b0);
    tick();
    chk("sub_valid", W'(out_valid), W'(1));
    drive(C_SLT, 32'hFFFF_FFFF, 32'h1);
    push("slt", 32'h1, 1'b0);
    tick();
    chk("slt_valid", W'(out_valid), W'(1));
    drive(C_SLTU, 32'hFFFF_FFFF, 32'h1);
    push("sltu", 32'h0, 1'b0);
    tick();
    chk("sltu_valid", W'(out_valid), W'(1));
    drive(C_NOR, 32'h0, 32'h0);
    push("nor", 32'hFFFF_FFFF, 1'b0);
    tick();
    chk("nor_valid", W'(out_valid), W'(1));
    drive(C_AND, 32'hF0F0_F0F0, 32'hFF00_FF00);
    push("and", 32'hF000_F000, 1'b0);
    tick();
    drive(C_OR, 32'h0F0F_0000, 32'h0000_00F0);
    push("or", 32'h0F0F_00F0, 1'b0);
    tick();
    drive(C_SUB, 32'h8000_0000, 32'h1);
    push("sub_ovf", 32'h7FFF_FFFF, 1'b1);
    tick();
    in_valid = 1'b0;
    tick();
    chk("idle_no_valid", W'(out_valid), '0);

    drive(C_MULT, 32'hFFFF_FFFD, 32'd7);
    mhi = 32'hFFFF_FFFF;
    mlo = 32'hFFFF_FFEB;
    push("mult", mlo, 1'b0);
    run_iter("mult", 1'b0, C_AND, '0, '0, edges, lows);
    chk("mult_edges", W'(edges), W'(34));
    chk("mult_ready_low", W'(lows), W'(33));

    drive(C_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    mhi = 32'hFFFF_FFFE;
    mlo = 32'h1;
    push("multu", mlo, 1'b0);
    run_iter("multu", 1'b0, C_AND, '0, '0, edges, lows);
    chk("multu_edges", W'(edges), W'(34));

    drive(C_DIV, 32'hFFFF_FFF9, 32'd2);
    mhi = 32'hFFFF_FFFF;
    mlo = 32'hFFFF_FFFD;
    push("div_neg", mlo, 1'b0);
    run_iter("div_neg", 1'b0, C_AND, '0, '0, edges, lows);
    chk("div_neg_edges", W'(edges), W'(34));

    drive(C_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    mhi = 32'h0;
    mlo = 32'h8000_0000;
    push("div_minneg", mlo, 1'b0);
    run_iter("div_minneg", 1'b0, C_AND, '0, '0, edges, lows);

    drive(C_DIV, 32'hFFFF_FFFB, 32'h0);
    mhi = 32'hFFFF_FFFB;
    mlo = 32'hFFFF_FFFF;
    push("div_by0", mlo, 1'b0);
    run_iter("div_by0", 1'b0, C_AND, '0, '0, edges, lows);

    drive(C_DIVU, 32'd9, 32'h0);
    mhi = 32'd9;
    mlo = 32'hFFFF_FFFF;
    push("divu_by0", mlo, 1'b0);
    run_iter("divu_by0", 1'b0, C_AND, '0, '0, edges, lows);

    drive(4'b1111, 32'd123, 32'd456);
    push("invalid", 32'h0, 1'b0);
    tick();
    chk("invalid_valid", W'(out_valid), W'(1));
    in_valid = 1'b0;

    drive(C_DIV, 32'd100, 32'd7);
    mhi = 32'd2;
    mlo = 32'd14;
    push("div_hold", mlo, 1'b0);
    push("add_after_div", 32'd5, 1'b0);
    run_iter("div_hold", 1'b1, C_ADD, 32'd2, 32'd3, edges, lows);
    chk("div_hold_edges", W'(edges), W'(34));
    tick();
    chk("add_after_div_valid", W'(out_valid), W'(1));
    in_valid = 1'b0;
    tick();

    drive(C_MULT, 32'd5, 32'd6);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("abort_out_valid", W'(out_valid), '0);
    chk("abort_in_ready",  W'(in_ready),  W'(1));
    chk("abort_hi",        hi,            '0);
    chk("abort_lo",        lo,            '0);
    chk("abort_result",    res,           '0);
    chk("abort_zero",      W'(zero),      W'(1));
    #2;
    reset = 1'b0;
    mhi   = '0;
    mlo   = '0;
    stray = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (out_valid) stray++;
    end
    chk("abort_no_pulse", W'(stray), '0);

    drive(C_ADD, 32'd1, 32'd1);
    push("add_post_reset", 32'd2, 1'b0);
    tick();
    in_valid = 1'b0;
    tick();

    chk("scoreboard_empty", W'(sbq.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
